fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 clock  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-003 imem_req  out  1  instruction-memory read request.
REQ-004 imem_addr  out  32  word-aligned fetch address; stable while imem_req=1 and imem_ready=0.
REQ-005 imem_ready  in  1  read data valid this cycle; meaningful only while imem_req=1.
REQ-006 imem_data  in  32  instruction word returned with imem_ready.
REQ-007 stall  in  1  decode-stage hold request from hazard logic.
REQ-008 selbrjumpz  in  2  from decoder: 00 sequential, 01 unconditional, 10 conditional, 11 treated as 00.
REQ-009 selpctype  in  2  target select: 00 PC+4+offset, 01 rs_value, 10 jump index, 11 treated as no redirect.
REQ-010 compout  in  1  branch comparator result for the instruction in decode.
REQ-011 rs_value  in  32  register RS value, used for JR.
REQ-012 imm  in  32  sign-extended immediate of the instruction in decode.
REQ-013 id_instr  out  32  IF/ID instruction register; 0 whenever id_valid=0.
REQ-014 id_pc4  out  32  address of the instruction in id_instr plus 4.
REQ-015 id_valid  out  1  id_instr holds a live instruction.
REQ-016 op  out  6  id_instr[31:26], feeding the control decoder.
REQ-017 fn  out  6  id_instr[5:0], feeding the control decoder.

Function
REQ-018 Redirect SHALL be asserted when id_valid=1 and either selbrjumpz=01 or (selbrjumpz=10 and compout=1), and selpctype is not 11.
REQ-019 Target SHALL be id_pc4+{imm[29:0],2'b00} (00), {rs_value[31:2],2'b00} (01), or {id_pc4[31:28],imm[25:0],2'b00} (10); all sums wrap mod 2^32.
REQ-020 FSM states SHALL be FETCH, HOLD and DROP.
REQ-021 FETCH: imem_req=1, imem_addr=PC; on imem_ready with stall=0, load id_instr=imem_data, id_pc4=PC+4 and id_valid=1; PC<=PC+4 the same edge.
REQ-022 FETCH on imem_ready with stall=1: capture the word and PC+4 into a hold register, advance PC, go to HOLD; IF/ID stays unchanged.
REQ-023 HOLD: imem_req=0; when stall=0, move the hold register into IF/ID and return to FETCH.
REQ-024 Redirect SHALL take priority over stall and over any returning data: PC<=target, id_valid<=0, id_instr<=0, and the hold register is discarded, all on the same edge.
REQ-025 Redirect in FETCH with imem_ready=1: discard the word and stay in FETCH at the target address.
REQ-026 Redirect in FETCH with imem_ready=0: go to DROP and keep imem_req=1 and imem_addr unchanged; on imem_ready, discard the word and go to FETCH at the saved target.
REQ-027 A second redirect while in DROP SHALL overwrite the saved target.
REQ-028 With stall=0 and memory ready every cycle, throughput SHALL be one instruction per cycle, with 1-cycle latency from the imem_ready edge to id_valid.
REQ-029 With id_valid=0, op and fn SHALL read 000000 (NOP).

Reset
REQ-030 When reset=0 at an edge: PC=0x00000000, state=FETCH, id_instr=0, id_pc4=0, id_valid=0, hold register cleared, saved target cleared.
REQ-031 While reset=0, imem_req SHALL be 0; imem_ready during reset SHALL be ignored.
REQ-032 Reset mid-transaction (FETCH, HOLD or DROP) SHALL abandon the pending access; the first request after release SHALL be to 0x00000000.

Configuration
REQ-033 With FETCH_TRACE_EN defined, every IF/ID load SHALL print time, PC and instruction via $display, and every redirect SHALL print the target.
REQ-034 Without FETCH_TRACE_EN, no display statements SHALL be compiled; functional behaviour is identical.

Verification
REQ-035 Reset release, memory always ready, words 0x20080005, 0x00000000 -> imem_addr 0,4,8; id_pc4 4 then 8; op=001000 on the first decode cycle.
REQ-036 stall=1 for 3 cycles while imem_ready=1 -> one word held, imem_req=0 during HOLD, IF/ID unchanged; word reaches IF/ID the cycle after stall falls.
REQ-037 BEQ in decode (id_pc4=0x10, imm=0x3, selbrjumpz=10, compout=1, selpctype=00) -> next imem_addr=0x1C, id_valid=0 for one cycle.
REQ-038 JR with rs_value=0x00400003 while the request is pending (imem_ready=0) -> DROP; the late word is discarded; next address 0x00400000.
REQ-039 J with id_pc4=0xF0000010, imm[25:0]=0x0000040 -> target 0xF0000100; PC=0xFFFFFFFC sequential -> wraps to 0x00000000.
REQ-040 reset=0 asserted in HOLD -> next cycle id_valid=0 and imem_req=0; after release, first imem_addr=0.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch stage with IF/ID register, stall hold buffer and redirect handling.
// Define FETCH_TRACE_EN to print IF/ID loads and redirect targets during simulation.
module fetch (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic [1:0]  selbrjumpz,
    input  logic [1:0]  selpctype,
    input  logic        compout,
    input  logic [31:0] rs_value,
    input  logic [31:0] imm,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [5:0]  op,
    output logic [5:0]  fn
);

    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next, pc_plus4;
    logic [31:0] hold_instr, hold_instr_next, hold_pc4, hold_pc4_next;
    logic [31:0] saved_target, saved_target_next;
    logic [31:0] id_instr_next, id_pc4_next;
    logic        id_valid_next;
    logic        taken, redirect;
    logic [31:0] target;

    assign pc_plus4  = pc + 32'd4;
    assign imem_req  = reset && (state != HOLD);
    assign imem_addr = pc;
    assign op        = id_instr[31:26];
    assign fn        = id_instr[5:0];

    always_comb begin
        taken    = (selbrjumpz == 2'b01) || ((selbrjumpz == 2'b10) && compout);
        redirect = id_valid && taken && (selpctype != 2'b11);
        case (selpctype)
            2'b00:   target = id_pc4 + {imm[29:0], 2'b00};
            2'b01:   target = {rs_value[31:2], 2'b00};
            2'b10:   target = {id_pc4[31:28], imm[25:0], 2'b00};
            default: target = pc_plus4;
        endcase
    end

    // Redirect wins over everything: it flushes IF/ID and the hold buffer on the same edge.
    always_comb begin
        state_next        = state;
        pc_next           = pc;
        hold_instr_next   = hold_instr;
        hold_pc4_next     = hold_pc4;
        saved_target_next = saved_target;
        id_instr_next     = id_instr;
        id_pc4_next       = id_pc4;
        id_valid_next     = id_valid;
        case (state)
            FETCH: begin
                if (redirect) begin
                    id_valid_next = 1'b0;
                    id_instr_next = 32'h0;
                    if (imem_ready) begin
                        pc_next = target;
                    end else begin
                        saved_target_next = target;
                        state_next        = DROP;
                    end
                end else if (imem_ready) begin
                    pc_next = pc_plus4;
                    if (stall) begin
                        hold_instr_next = imem_data;
                        hold_pc4_next   = pc_plus4;
                        state_next      = HOLD;
                    end else begin
                        id_instr_next = imem_data;
                        id_pc4_next   = pc_plus4;
                        id_valid_next = 1'b1;
                    end
                end else if (!stall) begin
                    // Decode consumed its instruction and nothing arrived: insert a bubble.
                    id_valid_next = 1'b0;
                    id_instr_next = 32'h0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    id_valid_next   = 1'b0;
                    id_instr_next   = 32'h0;
                    hold_instr_next = 32'h0;
                    hold_pc4_next   = 32'h0;
                    pc_next         = target;
                    state_next      = FETCH;
                end else if (!stall) begin
                    id_instr_next   = hold_instr;
                    id_pc4_next     = hold_pc4;
                    id_valid_next   = 1'b1;
                    hold_instr_next = 32'h0;
                    hold_pc4_next   = 32'h0;
                    state_next      = FETCH;
                end
            end
            DROP: begin
                if (redirect) begin
                    id_valid_next     = 1'b0;
                    id_instr_next     = 32'h0;
                    saved_target_next = target;
                end
                if (imem_ready) begin
                    pc_next           = redirect ? target : saved_target;
                    saved_target_next = 32'h0;
                    state_next        = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= FETCH;
            pc           <= 32'h0;
            hold_instr   <= 32'h0;
            hold_pc4     <= 32'h0;
            saved_target <= 32'h0;
            id_instr     <= 32'h0;
            id_pc4       <= 32'h0;
            id_valid     <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            hold_instr   <= hold_instr_next;
            hold_pc4     <= hold_pc4_next;
            saved_target <= saved_target_next;
            id_instr     <= id_instr_next;
            id_pc4       <= id_pc4_next;
            id_valid     <= id_valid_next;
        end
    end

`ifdef FETCH_TRACE_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            if (redirect)
                $display("%0t fetch redirect target=%h", $time, target);
            else if ((state == FETCH && imem_ready && !stall) || (state == HOLD && !stall))
                $display("%0t fetch load pc=%h instr=%h", $time, id_pc4_next - 32'd4, id_instr_next);
        end
    end
`endif

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus randomized traffic against a reference model.
module tb_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        stall = 1'b0;
    logic [1:0]  selbrjumpz = 2'b00;
    logic [1:0]  selpctype = 2'b00;
    logic        compout = 1'b0;
    logic [31:0] rs_value = 32'h0;
    logic [31:0] imm = 32'h0;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [5:0]  op;
    logic [5:0]  fn;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: next fetch address, decode slot, one parked word, one pending redirect.
    logic [31:0] m_pc, m_instr, m_pc4, m_hword, m_hpc4, m_saved;
    logic        m_valid, m_held, m_drop;

    fetch dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data), .stall(stall),
        .selbrjumpz(selbrjumpz), .selpctype(selpctype), .compout(compout),
        .rs_value(rs_value), .imm(imm), .id_instr(id_instr), .id_pc4(id_pc4),
        .id_valid(id_valid), .op(op), .fn(fn)
    );

    always #5 clock = ~clock;

    task automatic model_clear();
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_hword = 0; m_hpc4 = 0; m_saved = 0;
        m_valid = 0; m_held = 0; m_drop = 0;
    endtask

    task automatic tick(input logic rdy, input logic [31:0] data, input logic stl,
                        input logic [1:0] sbj, input logic [1:0] spt, input logic cmp,
                        input logic [31:0] rs, input logic [31:0] im);
        logic        redir;
        logic [31:0] tgt;
        imem_ready = rdy; imem_data = data; stall = stl; selbrjumpz = sbj;
        selpctype = spt; compout = cmp; rs_value = rs; imm = im;
        redir = m_valid && (sbj == 2'b01 || (sbj == 2'b10 && cmp)) && spt != 2'b11;
        case (spt)
            2'b00:   tgt = m_pc4 + im * 4;
            2'b01:   tgt = rs & 32'hFFFF_FFFC;
            default: tgt = (m_pc4 & 32'hF000_0000) | ((im & 32'h03FF_FFFF) << 2);
        endcase
        @(posedge clock);
        if (!reset) model_clear();
        else if (redir) begin
            m_valid = 0; m_instr = 0;
            if (m_held) begin m_held = 0; m_pc = tgt; end
            else if (m_drop) begin
                if (rdy) begin m_drop = 0; m_pc = tgt; end
                else m_saved = tgt;
            end
            else if (rdy) m_pc = tgt;
            else begin m_drop = 1; m_saved = tgt; end
        end else if (m_drop) begin
            if (rdy) begin m_drop = 0; m_pc = m_saved; end
        end else if (m_held) begin
            if (!stl) begin m_held = 0; m_valid = 1; m_instr = m_hword; m_pc4 = m_hpc4; end
        end else if (rdy) begin
            if (stl) begin m_held = 1; m_hword = data; m_hpc4 = m_pc + 4; end
            else begin m_valid = 1; m_instr = data; m_pc4 = m_pc + 4; end
            m_pc = m_pc + 4;
        end else if (!stl) begin
            m_valid = 0; m_instr = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1'($urandom), $urandom, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req: got %b want 0", imem_req); end
        end
        reset = 1'b1;
        #1;
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL release_req: got %b want 1", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL release_addr: got %h want 0", imem_addr); end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL release_valid: got %b want 0", id_valid); end
        vectors++; if (id_instr !== 32'h0) begin miscompares++; $display("[TB] FAIL release_instr: got %h want 0", id_instr); end
        vectors++; if (id_pc4 !== 32'h0) begin miscompares++; $display("[TB] FAIL release_pc4: got %h want 0", id_pc4); end
    endtask

    task automatic test_sequential();
        tick(1'b1, 32'h2008_0005, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL seq_valid: got %b want 1", id_valid); end
        vectors++; if (op !== 6'b001000) begin miscompares++; $display("[TB] FAIL seq_op: got %b want 001000", op); end
        vectors++; if (fn !== 6'b000101) begin miscompares++; $display("[TB] FAIL seq_fn: got %b want 000101", fn); end
        vectors++; if (id_pc4 !== 32'h4) begin miscompares++; $display("[TB] FAIL seq_pc4a: got %h want 4", id_pc4); end
        vectors++; if (imem_addr !== 32'h4) begin miscompares++; $display("[TB] FAIL seq_addr4: got %h want 4", imem_addr); end
        tick(1'b1, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        vectors++; if (id_pc4 !== 32'h8) begin miscompares++; $display("[TB] FAIL seq_pc4b: got %h want 8", id_pc4); end
        vectors++; if (imem_addr !== 32'h8) begin miscompares++; $display("[TB] FAIL seq_addr8: got %h want 8", imem_addr); end
        vectors++; if (op !== 6'b000000) begin miscompares++; $display("[TB] FAIL seq_op_nop: got %b want 000000", op); end
    endtask

    task automatic test_stall();
        tick(1'b1, 32'h8C22_0004, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_req: got %b want 0", imem_req); end
            vectors++; if (id_pc4 !== 32'h8 || id_instr !== 32'h0) begin miscompares++; $display("[TB] FAIL hold_ifid: got %h/%h want 8/0", id_pc4, id_instr); end
            tick(1'b0, 32'h0, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        end
        tick(1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        vectors++; if (id_instr !== 32'h8C22_0004) begin miscompares++; $display("[TB] FAIL unhold_instr: got %h want 8c220004", id_instr); end
        vectors++; if (id_pc4 !== 32'hC) begin miscompares++; $display("[TB] FAIL unhold_pc4: got %h want c", id_pc4); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin miscompares++; $display("[TB] FAIL unhold_req: got %b/%h want 1/c", imem_req, imem_addr); end
    endtask

    task automatic test_branch();
        tick(1'b1, 32'h1043_0003, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        tick(1'b1, 32'hAAAA_AAAA, 1'b0, 2'b10, 2'b00, 1'b1, 32'h0, 32'h3);
        vectors++; if (imem_addr !== 32'h1C) begin miscompares++; $display("[TB] FAIL beq_addr: got %h want 1c", imem_addr); end
        vectors++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin miscompares++; $display("[TB] FAIL beq_flush: got %b/%h want 0/0", id_valid, id_instr); end
        tick(1'b1, 32'h0123_4567, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        vectors++; if (id_valid !== 1'b1 || id_pc4 !== 32'h20) begin miscompares++; $display("[TB] FAIL beq_target_fetch: got %b/%h want 1/20", id_valid, id_pc4); end
    endtask

    task automatic test_jr_drop();
        tick(1'b0, 32'h0, 1'b0, 2'b01, 2'b01, 1'b0, 32'h0040_0003, 32'h0);
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin miscompares++; $display("[TB] FAIL drop_req: got %b/%h want 1/20", imem_req, imem_addr); end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_valid: got %b want 0", id_valid); end
        tick(1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        vectors++; if (imem_addr !== 32'h20) begin miscompares++; $display("[TB] FAIL drop_stable: got %h want 20", imem_addr); end
        tick(1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        vectors++; if (imem_addr !== 32'h0040_0000) begin miscompares++; $display("[TB] FAIL jr_addr: got %h want 00400000", imem_addr); end
        vectors++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin miscompares++; $display("[TB] FAIL drop_discard: got %b/%h want 0/0", id_valid, id_instr); end
        tick(1'b1, 32'h03E0_0008, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        vectors++; if (id_pc4 !== 32'h0040_0004) begin miscompares++; $display("[TB] FAIL jr_pc4: got %h want 00400004", id_pc4); end
    endtask

    task automatic test_jump_wrap();
        tick(1'b1, 32'h0, 1'b0, 2'b01, 2'b01, 1'b0, 32'hF000_000C, 32'h0);
        tick(1'b1, 32'h0800_0040, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        vectors++; if (id_pc4 !== 32'hF000_0010) begin miscompares++; $display("[TB] FAIL j_pc4: got %h want f0000010", id_pc4); end
        tick(1'b1, 32'h0, 1'b0, 2'b01, 2'b10, 1'b0, 32'h0, 32'h0000_0040);
        vectors++; if (imem_addr !== 32'hF000_0100) begin miscompares++; $display("[TB] FAIL j_addr: got %h want f0000100", imem_addr); end
        tick(1'b1, 32'h1111_1111, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        tick(1'b1, 32'h0, 1'b0, 2'b01, 2'b01, 1'b0, 32'hFFFF_FFFC, 32'h0);
        vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL wrap_pre: got %h want fffffffc", imem_addr); end
        tick(1'b1, 32'h2222_2222, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        vectors++; if (imem_addr !== 32'h0 || id_pc4 !== 32'h0) begin miscompares++; $display("[TB] FAIL wrap: got addr %h pc4 %h want 0/0", imem_addr, id_pc4); end
    endtask

    task automatic test_reset_in_hold();
        tick(1'b1, 32'h3333_3333, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rh_hold: got %b want 0", imem_req); end
        reset = 1'b0;
        tick(1'b1, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        vectors++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rh_reset: got valid %b req %b want 0/0", id_valid, imem_req); end
        reset = 1'b1;
        #1;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rh_release: got %b/%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_random();
        logic exp_req;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) != 0);
            tick($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) == 0,
                 2'($urandom), 2'($urandom), 1'($urandom), $urandom,
                 32'($signed(10'($urandom))));
            exp_req = reset && !m_held;
            vectors++; if (imem_req !== exp_req) begin miscompares++; $display("[TB] FAIL rnd_req[%0d]: got %b want %b", i, imem_req, exp_req); end
            if (exp_req) begin
                vectors++; if (imem_addr !== m_pc) begin miscompares++; $display("[TB] FAIL rnd_addr[%0d]: got %h want %h", i, imem_addr, m_pc); end
            end
            vectors++; if (id_valid !== m_valid) begin miscompares++; $display("[TB] FAIL rnd_valid[%0d]: got %b want %b", i, id_valid, m_valid); end
            vectors++; if (id_instr !== m_instr) begin miscompares++; $display("[TB] FAIL rnd_instr[%0d]: got %h want %h", i, id_instr, m_instr); end
            vectors++; if (op !== m_instr[31:26] || fn !== m_instr[5:0]) begin miscompares++; $display("[TB] FAIL rnd_opfn[%0d]: got %b/%b want %b/%b", i, op, fn, m_instr[31:26], m_instr[5:0]); end
            if (m_valid) begin
                vectors++; if (id_pc4 !== m_pc4) begin miscompares++; $display("[TB] FAIL rnd_pc4[%0d]: got %h want %h", i, id_pc4, m_pc4); end
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        model_clear();
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jr_drop();
        test_jump_wrap();
        test_reset_in_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
